instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Front end of the single-issue MIPS datapath. Owns the PC and issues word fetches to instruction memory over a req/ack handshake. Buffers returned words in a small prefetch queue and presents them to decode with a valid/ready handshake. Drives instr_op directly into the opcode decoder, and accepts branch redirects from execute.

Parameters:
PC_WIDTH, 32, width of PC, addresses and instruction words
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, prefetch queue entries; power of two, minimum 2

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (reset==0 resets)
imem_req  output  1  fetch request, registered
imem_addr  output  PC_WIDTH  fetch address, registered, word aligned
imem_ack  input  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  input  PC_WIDTH  fetched instruction word
branch_taken  input  1  redirect strobe from execute
branch_target  input  PC_WIDTH  redirect address; bits [1:0] ignored, forced to 0
id_ready  input  1  decode stage can accept an instruction
id_valid  output  1  queue head valid
id_instr  output  PC_WIDTH  queue head instruction; 0 when empty
id_pc_plus4  output  PC_WIDTH  fetch address of head + 4
instr_op  output  6  id_instr[31:26], to the control decoder

Behaviour:
- Reset (async assert):
  - imem_req=0, imem_addr=RESET_PC.
  - Queue empty: id_valid=0, id_instr=0, id_pc_plus4=0, instr_op=0.
  - FSM=IDLE, fetch PC=RESET_PC.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its response will be kept.
  - DROP: request outstanding; its response will be discarded.
- Issue rule: a new request may issue only when (occupancy after this cycle's push and pop) < BUF_DEPTH. Only one request may be outstanding at a time.
- IDLE and space available: next edge sets imem_req=1, imem_addr=PC, and moves to WAIT. The first request is visible on the first edge after reset deasserts.
- imem_req and imem_addr stay stable until the cycle imem_ack=1. imem_ack is never sampled in the same cycle imem_req first rises.
- WAIT and imem_ack:
  - imem_rdata and its address are pushed into the queue, and PC += 4.
  - If space remains, the same edge issues the next request (req stays 1, addr updates); otherwise imem_req=0 and the FSM goes to IDLE.
  - Peak throughput is one instruction per cycle with a 1-cycle-latency memory.
- Dequeue: id_valid && id_ready pops the head on that edge. Push and pop in the same cycle are allowed at any occupancy, including full.
- Redirect (branch_taken=1) has the highest priority:
  - Queue is flushed; any same-cycle pop or push is void.
  - PC = {branch_target[PC_WIDTH-1:2], 2'b00}.
  - WAIT becomes DROP, or IDLE if imem_ack arrives this same cycle (that word is discarded).
  - In IDLE, the next edge requests the target.
- DROP:
  - imem_req stays 1 with the old address until ack; the response is discarded.
  - Then the FSM goes to IDLE, and the next edge requests the target.
  - A further branch_taken in DROP only updates PC.
- Queue pointers wrap modulo BUF_DEPTH. Occupancy is a counter 0..BUF_DEPTH; overflow is impossible by the issue rule.
- PC wraps at 2^PC_WIDTH with no flag.
- Async reset mid-transaction abandons the outstanding request. Instruction memory must ignore a late ack after reset.

Optional Feature:
FETCH_PERF_CNT_EN defined:
- Adds outputs fetch_count[31:0] (responses pushed) and drop_count[31:0] (responses discarded, plus entries flushed).
- Both counters clear on reset and wrap.

FETCH_PERF_CNT_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_ADDI=6'b001000
  - fetch FSM state encoding
  - PC increment constant 4
- One sub-module fetch_queue: parameterised synchronous FIFO with push, pop, flush, count, and head outputs.

Test Plan:
1. Reset release, memory ack one cycle after each req:
   - Addresses 0x0, 0x4, 0x8 are fetched back to back.
   - id_valid=1 two edges after the first req.
   - instr_op=6'b100011 for word 0x8C010004.
2. id_ready=0 with BUF_DEPTH=2:
   - Exactly 2 words are fetched, then imem_req=0 and the FSM holds IDLE.
   - Raising id_ready resumes at 0x8.
3. Ack delayed 3 cycles: imem_req and imem_addr=0x4 are held stable for all 3 cycles, and no second request is issued.
4. branch_taken with target 0x103 while WAIT on 0x8:
   - The queue empties immediately.
   - The 0x8 response is dropped.
   - The next request addr=0x100, and the head's id_pc_plus4=0x104.
5. branch_taken in the same cycle as imem_ack: the word is discarded, and req to the target is issued on the next edge.
6. reset pulsed low while WAIT: all outputs return to reset values asynchronously, and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, fetch FSM encoding and PC step.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam int unsigned PC_INCR = 4;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: imem req/ack, branch redirect and decode handshake.
interface instr_fetch_unit_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [PC_WIDTH-1:0] imem_rdata;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic                id_ready;
    logic                id_valid;
    logic [PC_WIDTH-1:0] id_instr;
    logic [PC_WIDTH-1:0] id_pc_plus4;
    logic [5:0]          instr_op;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc_plus4, instr_op,
        input  imem_ack, imem_rdata, branch_taken, branch_target, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc_plus4, instr_op,
        output imem_ack, imem_rdata, branch_taken, branch_target, id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; head reads as zero while empty.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             push_data_i,
    output logic [WIDTH-1:0]             head_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner and instruction fetcher feeding decode through a prefetch queue.
// Defining FETCH_PERF_CNT_EN adds fetch_count/drop_count performance counters.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned         PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned         BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        drop_count
`endif
);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic                req_q, req_d;

    logic [PC_WIDTH-1:0]   target, pc_incr;
    logic                  flush, push, pop, drop_ack, space, head_valid;
    logic [CNT_W-1:0]      q_count;
    logic [CNT_W:0]        occ_next;
    logic [2*PC_WIDTH-1:0] head;
    logic                  unused_tgt_lsb;

    assign target         = {bus.branch_target[PC_WIDTH-1:2], 2'b00};
    assign unused_tgt_lsb = ^bus.branch_target[1:0];
    assign pc_incr        = pc_q + PC_WIDTH'(PC_INCR);

    // Redirect voids any same-cycle push or pop.
    assign flush      = bus.branch_taken;
    assign head_valid = (q_count != '0);
    assign push       = (state_q == FS_WAIT) && bus.imem_ack && !flush;
    assign pop        = head_valid && bus.id_ready && !flush;
    assign drop_ack   = bus.imem_ack &&
                        ((state_q == FS_DROP) || ((state_q == FS_WAIT) && flush));

    assign occ_next = flush ? '0
                            : {1'b0, q_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
    assign space    = occ_next < (CNT_W+1)'(BUF_DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        if (flush) pc_d = target;
        unique case (state_q)
            FS_IDLE: begin
                if (space) begin
                    req_d   = 1'b1;
                    addr_d  = pc_d;
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (flush) begin
                    if (bus.imem_ack) begin
                        req_d   = 1'b0;
                        state_d = FS_IDLE;
                    end else begin
                        state_d = FS_DROP;
                    end
                end else if (bus.imem_ack) begin
                    pc_d = pc_incr;
                    if (space) begin
                        addr_d = pc_incr;
                    end else begin
                        req_d   = 1'b0;
                        state_d = FS_IDLE;
                    end
                end
            end
            FS_DROP: begin
                if (bus.imem_ack) begin
                    req_d   = 1'b0;
                    state_d = FS_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = FS_IDLE;
            end
        endcase
    end

    fetch_queue #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (2 * PC_WIDTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (flush),
        .push_data_i ({bus.imem_rdata, addr_q + PC_WIDTH'(PC_INCR)}),
        .head_data_o (head),
        .count_o     (q_count)
    );

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.id_valid    = head_valid;
    assign bus.id_instr    = head[2*PC_WIDTH-1:PC_WIDTH];
    assign bus.id_pc_plus4 = head[PC_WIDTH-1:0];
    assign bus.instr_op    = head[2*PC_WIDTH-1 -: 6];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, drop_cnt_q;

    // Drops count discarded responses plus entries thrown away by a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(push);
            drop_cnt_q  <= drop_cnt_q + 32'(drop_ack) + (flush ? 32'(q_count) : 32'd0);
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign drop_count  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model, scoreboard monitor, scenario tasks.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    localparam int unsigned PW     = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    instr_fetch_unit_if #(.PC_WIDTH(PW)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, drop_count;
`endif

    instr_fetch_unit #(
        .PC_WIDTH  (PW),
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .drop_count  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 1;
    exp_t        sb[$];
    logic [31:0] exp_pc = RST_PC;
    bit          drop_pending = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h8C01_0004 : ((a * 32'h9E37_79B1) ^ 32'h0123_4567);
    endfunction

    task automatic next_sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int lat, input logic rdy);
        @(posedge clk); #3;
        reset = 1'b0;
        bus.branch_taken = 1'b0;
        bus.id_ready = rdy;
        mem_lat = lat;
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b1;
    endtask

    // Instruction memory: acks mem_lat cycles after a request appears.
    task automatic mem_model();
        int cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                bus.imem_ack = 1'b0;
                cnt = 0;
            end else begin
                if (bus.imem_ack) begin
                    bus.imem_ack = 1'b0;
                    cnt = 0;
                end
                if (bus.imem_req) begin
                    cnt++;
                    if (cnt >= mem_lat) begin
                        bus.imem_ack   = 1'b1;
                        bus.imem_rdata = mem_word(bus.imem_addr);
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    endtask

    // Tracks expected fetch PC, drops and flushes; checks every pop to decode.
    task automatic scoreboard_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sb.delete();
                exp_pc = RST_PC;
                drop_pending = 1'b0;
                continue;
            end
            if (bus.id_valid === 1'b1 && bus.id_ready && !bus.branch_taken) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop: got instr=%h pc4=%h, required no valid entry",
                             bus.id_instr, bus.id_pc_plus4);
                end else begin
                    e = sb.pop_front();
                    if (bus.id_instr !== e.instr || bus.id_pc_plus4 !== e.pc4) begin
                        errors++;
                        $display("FAIL sb_pop: got instr=%h pc4=%h, required instr=%h pc4=%h",
                                 bus.id_instr, bus.id_pc_plus4, e.instr, e.pc4);
                    end
                end
            end
            if (bus.branch_taken) begin
                drop_pending = (bus.imem_req === 1'b1) && !bus.imem_ack;
                sb.delete();
                exp_pc = {bus.branch_target[31:2], 2'b00};
            end else if (bus.imem_ack && bus.imem_req === 1'b1) begin
                if (drop_pending) begin
                    drop_pending = 1'b0;
                end else begin
                    checks++;
                    if (bus.imem_addr !== exp_pc) begin
                        errors++;
                        $display("FAIL sb_addr: got addr=%h, required %h", bus.imem_addr, exp_pc);
                    end
                    sb.push_back('{instr: mem_word(exp_pc), pc4: exp_pc + 32'd4});
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks += 6;
        if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b, required 0", bus.imem_req); end
        if (bus.imem_addr !== RST_PC) begin errors++; $display("FAIL rst_addr: got %h, required %h", bus.imem_addr, RST_PC); end
        if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", bus.id_valid); end
        if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h, required 0", bus.id_instr); end
        if (bus.id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h, required 0", bus.id_pc_plus4); end
        if (bus.instr_op !== 6'h0) begin errors++; $display("FAIL rst_op: got %b, required 0", bus.instr_op); end
    endtask

    task automatic test_back_to_back();
        do_reset(1, 1'b1);
        next_sample();
        checks += 3;
        if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL b2b_req0: got %b, required 1", bus.imem_req); end
        if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL b2b_addr0: got %h, required 0", bus.imem_addr); end
        if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_early: got %b, required 0", bus.id_valid); end
        next_sample();
        checks += 4;
        if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b, required 1", bus.id_valid); end
        if (bus.id_instr !== 32'h8C01_0004) begin errors++; $display("FAIL b2b_instr: got %h, required 8c010004", bus.id_instr); end
        if (bus.instr_op !== OP_LW) begin errors++; $display("FAIL b2b_op: got %b, required %b", bus.instr_op, OP_LW); end
        if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL b2b_addr4: got %h, required 4", bus.imem_addr); end
        next_sample();
        checks++;
        if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL b2b_addr8: got %h, required 8", bus.imem_addr); end
        repeat (6) next_sample();
    endtask

    task automatic test_backpressure();
        do_reset(1, 1'b0);
        next_sample();
        for (int i = 0; i < 10 && bus.imem_req; i++) next_sample();
        checks += 3;
        if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_stop: got req=%b, required 0", bus.imem_req); end
        if (sb.size() != 2) begin errors++; $display("FAIL bp_count: got %0d words, required 2", sb.size()); end
        if (bus.id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL bp_head: got pc4=%h, required 4", bus.id_pc_plus4); end
        for (int i = 0; i < 3; i++) begin
            next_sample();
            checks++;
            if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_hold: got req=%b, required 0", bus.imem_req); end
        end
        @(posedge clk); #1;
        bus.id_ready = 1'b1;
        next_sample();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8)
            begin errors++; $display("FAIL bp_resume: got req=%b addr=%h, required 1 8", bus.imem_req, bus.imem_addr); end
        repeat (4) next_sample();
    endtask

    task automatic test_ack_delay();
        do_reset(3, 1'b1);
        for (int i = 0; i < 20; i++) begin
            next_sample();
            if (bus.imem_req && bus.imem_addr == 32'h4) break;
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) next_sample();
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4)
                begin errors++; $display("FAIL delay_hold%0d: got req=%b addr=%h, required 1 4", k, bus.imem_req, bus.imem_addr); end
        end
        next_sample();
        checks++;
        if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL delay_next: got addr=%h, required 8", bus.imem_addr); end
    endtask

    task automatic test_branch();
        do_reset(3, 1'b0);
        next_sample();
        for (int i = 0; i < 30 && !(bus.imem_req == 1'b0 && bus.id_valid == 1'b1); i++) next_sample();
        checks++;
        if (bus.imem_req !== 1'b0 || bus.id_valid !== 1'b1)
            begin errors++; $display("FAIL br_full: got req=%b valid=%b, required 0 1", bus.imem_req, bus.id_valid); end
        @(posedge clk); #1; bus.id_ready = 1'b1;
        @(posedge clk); #1; bus.id_ready = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0103;
        @(posedge clk); #1; bus.branch_taken = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h0)
            begin errors++; $display("FAIL br_flush: got valid=%b instr=%h, required 0 0", bus.id_valid, bus.id_instr); end
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8)
            begin errors++; $display("FAIL br_drop_hold: got req=%b addr=%h, required 1 8", bus.imem_req, bus.imem_addr); end
        for (int i = 0; i < 20 && !(bus.imem_req && bus.imem_addr == 32'h100); i++) next_sample();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100)
            begin errors++; $display("FAIL br_target: got req=%b addr=%h, required 1 100", bus.imem_req, bus.imem_addr); end
        @(posedge clk); #1; bus.id_ready = 1'b1;
        for (int i = 0; i < 20 && bus.id_valid !== 1'b1; i++) next_sample();
        checks++;
        if (bus.id_pc_plus4 !== 32'h104 || bus.id_instr !== mem_word(32'h100))
            begin errors++; $display("FAIL br_head: got pc4=%h instr=%h, required 104 %h", bus.id_pc_plus4, bus.id_instr, mem_word(32'h100)); end
        repeat (3) next_sample();
    endtask

    task automatic test_branch_with_ack();
        do_reset(1, 1'b1);
        repeat (3) next_sample();
        @(posedge clk); #2;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_ack !== 1'b1)
            begin errors++; $display("FAIL bra_pre: got req=%b ack=%b, required 1 1", bus.imem_req, bus.imem_ack); end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0202;
        @(posedge clk); #2; bus.branch_taken = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b0 || bus.id_valid !== 1'b0)
            begin errors++; $display("FAIL bra_idle: got req=%b valid=%b, required 0 0", bus.imem_req, bus.id_valid); end
        next_sample();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200)
            begin errors++; $display("FAIL bra_target: got req=%b addr=%h, required 1 200", bus.imem_req, bus.imem_addr); end
        repeat (4) next_sample();
    endtask

    task automatic test_reset_mid();
        do_reset(3, 1'b0);
        next_sample();
        for (int i = 0; i < 20 && !(bus.id_valid == 1'b1 && bus.imem_req == 1'b1); i++) next_sample();
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        checks += 2;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== RST_PC)
            begin errors++; $display("FAIL mid_rst_req: got req=%b addr=%h, required 0 %h", bus.imem_req, bus.imem_addr, RST_PC); end
        if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h0 || bus.id_pc_plus4 !== 32'h0 || bus.instr_op !== 6'h0)
            begin errors++; $display("FAIL mid_rst_q: got valid=%b instr=%h pc4=%h op=%b, required all 0",
                                     bus.id_valid, bus.id_instr, bus.id_pc_plus4, bus.instr_op); end
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b1;
        bus.id_ready = 1'b1;
        next_sample();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC)
            begin errors++; $display("FAIL mid_restart: got req=%b addr=%h, required 1 %h", bus.imem_req, bus.imem_addr, RST_PC); end
        repeat (6) next_sample();
    endtask

    task automatic test_random_traffic();
        do_reset(1, 1'b1);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            bus.id_ready      = 1'($urandom_range(0, 1));
            mem_lat           = int'($urandom_range(1, 3));
            bus.branch_taken  = ($urandom_range(0, 15) == 0);
            bus.branch_target = 32'($urandom_range(0, 4095));
        end
        @(posedge clk); #1;
        bus.branch_taken = 1'b0;
        bus.id_ready     = 1'b1;
        repeat (10) next_sample();
    endtask

    initial begin
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = '0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.id_ready      = 1'b0;
        fork
            mem_model();
            scoreboard_monitor();
        join_none
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_ack_delay();
        test_branch();
        test_branch_with_ack();
        test_reset_mid();
        test_random_traffic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
